sump_cmd_receiver: RTL
======================

Name: sump_cmd_receiver

Overview:
Parametrised UART receiver with integrated SUMP command framing for the logic-analyser host link. It oversamples the asynchronous rx line, recovers bytes with optional parity and 1 or 2 stop bits, and assembles them into commands. Short commands (opcode bit7=0) are 1 byte; long commands (bit7=1) are opcode plus 4 data bytes, with an inter-byte timeout. It sits between the rx pin and the command decoder in ACSP_top and replaces the fixed 8N1 receive path.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency
BAUD_RATE, 9600, line rate
OVERSAMPLE, 16, ticks per bit; must be even and >=8
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, 1 or 2
TIMEOUT_CHARS, 16, character times allowed between bytes of a long command

Ports:
system_clock  in  1  clock
ext_reset_n  in  1  reset, synchronous, active-low
rx  in  1  asynchronous serial input, idle high
byte_valid  out  1  1-cycle pulse, byte_data valid
byte_data  out  8  last received byte
cmd_valid  out  1  1-cycle pulse, command outputs valid
cmd_opcode  out  8  command opcode
cmd_data  out  32  long-command payload; first data byte in [31:24]
cmd_long  out  1  1 = 5-byte command
cmd_busy  out  1  long command partially received
frame_err  out  1  1-cycle pulse, stop bit sampled low
parity_err  out  1  1-cycle pulse, parity mismatch
timeout_err  out  1  1-cycle pulse, long command abandoned

Behaviour:
- One clock: system_clock. Reset is synchronous, active-low on ext_reset_n. All state resets on the clock edge with ext_reset_n=0.
- Reset values: all outputs 0. Synchroniser flops reset to 1. Both FSMs return to IDLE. Reset mid-frame discards the partial byte and the partial command, with no error pulses.
- rx passes through a 2-flop synchroniser. Tick divider DIV = round(CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE)), minimum 1. The tick counter free-runs.
- RX FSM: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE to START on synchronised rx low.
  - START: after OVERSAMPLE/2 ticks, re-sample. If high, treat as a glitch and return to IDLE with no output. If low, go to DATA.
  - DATA: 8 samples, one every OVERSAMPLE ticks, LSB first.
  - PARITY: entered only if PARITY!=0.
  - STOP: STOP_BITS samples. Any stop sample low pulses frame_err, discards the byte, and enters BREAK. BREAK waits for rx high, then IDLE.
  - Parity mismatch pulses parity_err and discards the byte. It is reported after the stop bits, in the same cycle the byte would have completed.
  - Good byte: byte_valid pulses in the cycle after the final stop-bit sample.
- Assembler FSM: A_IDLE, A_COLLECT (count 0..3).
  - In A_IDLE, a byte with bit7=0 gives cmd_valid one cycle after byte_valid, with cmd_opcode=byte, cmd_data=0, cmd_long=0.
  - In A_IDLE, a byte with bit7=1 latches the opcode, sets cmd_busy=1, and goes to A_COLLECT.
  - In A_COLLECT, each byte shifts into cmd_data MSB-first. After the 4th byte, cmd_valid with cmd_long=1 fires one cycle after that byte_valid. cmd_busy falls in the same cycle. Return to A_IDLE.
  - In A_COLLECT, frame_err or parity_err aborts the command: return to A_IDLE, cmd_busy=0, no cmd_valid.
  - Timeout: counter cleared on each byte_valid. Expires after TIMEOUT_CHARS*OVERSAMPLE*(10+(PARITY!=0)+STOP_BITS-1) ticks while in A_COLLECT. Expiry pulses timeout_err, clears cmd_busy, and returns to A_IDLE.
  - If a byte completes in the same cycle as timeout expiry, the byte wins and the counter is cleared.
- cmd_opcode, cmd_data and cmd_long hold their values until the next cmd_valid. byte_data holds until the next byte_valid.
- Back-to-back frames with no idle gap between stop and start are received without loss.

Test Plan:
- Defaults (DIV=651). Five frames 0x00 -> five cmd_valid pulses, opcode 0x00, cmd_long=0, cmd_data=0, no errors.
- Frames 0x80,0x00,0x12,0x34,0x56 -> exactly one cmd_valid, 1 cycle after the 5th byte_valid. opcode=0x80, data=0x00123456, cmd_long=1. cmd_busy high from the 1st to the 5th byte.
- rx low pulse of 0.25 bit then high -> no byte_valid, no errors. A following 0x04 frame -> short cmd 0x04.
- 0xC1 then a frame with stop bit forced 0 -> frame_err pulse, cmd_busy=0, no cmd_valid. Then 0x02 -> short cmd 0x02.
- PARITY=2: 0x81 with parity bit 0 (correct is 0) -> byte accepted. Repeat with parity bit 1 -> parity_err, no byte_valid.
- 0x81,0x00 then idle beyond the timeout -> timeout_err once. Next 0x01 -> short cmd 0x01. Asserting ext_reset_n=0 mid-frame -> all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/sump_cmd_receiver.sv
// sump_cmd_receiver: oversampling UART receiver that frames SUMP short/long commands
module sump_cmd_receiver #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int OVERSAMPLE    = 16,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int TIMEOUT_CHARS = 16
) (
  input  logic        system_clock,
  input  logic        ext_reset_n,
  input  logic        rx,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_data,
  output logic        cmd_long,
  output logic        cmd_busy,
  output logic        frame_err,
  output logic        parity_err,
  output logic        timeout_err
);
  localparam int DIV_RAW = (CLK_FREQ_HZ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW      = DIV > 1 ? $clog2(DIV) : 1;
  localparam int OW      = $clog2(OVERSAMPLE);
  localparam int TO_LIM  = TIMEOUT_CHARS * OVERSAMPLE * (10 + (PARITY != 0 ? 1 : 0) + STOP_BITS - 1);
  localparam int TW      = $clog2(TO_LIM + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_LIM);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic {A_IDLE, A_COLLECT} a_state_t;
  logic [1:0]    sync_q;
  logic [DW-1:0] div_q, div_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [OW-1:0] os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    rsh_q, rsh_d;
  logic          perr_q, perr_d;
  logic          byte_valid_q, byte_valid_d, frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic [7:0]    byte_data_q, byte_data_d;
  a_state_t      a_state_q, a_state_d;
  logic [1:0]    n_q, n_d;
  logic [7:0]    op_q, op_d;
  logic [23:0]   acc_q, acc_d;
  logic [TW-1:0] to_q, to_d;
  logic          cmd_valid_q, cmd_valid_d, cmd_long_q, cmd_long_d, cmd_busy_q, cmd_busy_d;
  logic          timeout_err_q, timeout_err_d;
  logic [7:0]    cmd_opcode_q, cmd_opcode_d;
  logic [31:0]   cmd_data_q, cmd_data_d;
  logic          rx_s, tick, samp, exp_par;
  assign rx_s    = sync_q[1];
  assign tick    = div_q == DW'(DIV - 1);
  assign div_d   = tick ? '0 : div_q + 1'b1;
  assign samp    = tick && os_q == (rx_state_q == R_START ? OW'(OVERSAMPLE / 2 - 1) : OW'(OVERSAMPLE - 1));
  assign exp_par = PARITY == 1 ? ~^rsh_q : ^rsh_q;
  always_comb begin
    rx_state_d   = rx_state_q;
    os_d         = rx_state_q == R_IDLE ? '0 : samp ? '0 : os_q + OW'(tick);
    bit_d        = bit_q;
    rsh_d        = rsh_q;
    perr_d       = perr_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    byte_data_d  = byte_data_q;
    unique case (rx_state_q)
      R_IDLE: begin
        bit_d  = '0;
        perr_d = 1'b0;
        if (!rx_s) rx_state_d = R_START;
      end
      R_START: if (samp) rx_state_d = rx_s ? R_IDLE : R_DATA;
      R_DATA: if (samp) begin
        rsh_d = {rx_s, rsh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) rx_state_d = PARITY != 0 ? R_PARITY : R_STOP;
      end
      R_PARITY: if (samp) begin
        perr_d     = rx_s != exp_par;
        rx_state_d = R_STOP;
      end
      R_STOP: if (samp) begin
        bit_d = bit_q + 1'b1;
        if (!rx_s) begin
          frame_err_d = 1'b1;
          rx_state_d  = R_BREAK;
        end else if (bit_q == 3'(STOP_BITS - 1)) begin
          rx_state_d   = R_IDLE;
          parity_err_d = perr_q;
          byte_valid_d = !perr_q;
          byte_data_d  = perr_q ? byte_data_q : rsh_q;
        end
      end
      R_BREAK: if (rx_s) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end
  always_comb begin
    a_state_d     = a_state_q;
    n_d           = n_q;
    op_d          = op_q;
    acc_d         = acc_q;
    to_d          = (byte_valid_q || a_state_q == A_IDLE) ? '0 : to_q + TW'(tick);
    cmd_valid_d   = 1'b0;
    cmd_opcode_d  = cmd_opcode_q;
    cmd_data_d    = cmd_data_q;
    cmd_long_d    = cmd_long_q;
    cmd_busy_d    = cmd_busy_q;
    timeout_err_d = 1'b0;
    if (a_state_q == A_IDLE) begin
      if (byte_valid_q && !byte_data_q[7]) begin
        cmd_valid_d  = 1'b1;
        cmd_opcode_d = byte_data_q;
        cmd_data_d   = '0;
        cmd_long_d   = 1'b0;
      end else if (byte_valid_q) begin
        op_d       = byte_data_q;
        n_d        = '0;
        cmd_busy_d = 1'b1;
        a_state_d  = A_COLLECT;
      end
    end else if (byte_valid_q) begin
      acc_d = {acc_q[15:0], byte_data_q};
      n_d   = n_q + 1'b1;
      if (n_q == 2'd3) begin
        cmd_valid_d  = 1'b1;
        cmd_opcode_d = op_q;
        cmd_data_d   = {acc_q, byte_data_q};
        cmd_long_d   = 1'b1;
        cmd_busy_d   = 1'b0;
        a_state_d    = A_IDLE;
      end
    end else if (frame_err_q || parity_err_q || to_q == TO_MAX) begin
      // a line error takes precedence over a timeout landing in the same cycle
      timeout_err_d = !(frame_err_q || parity_err_q);
      cmd_busy_d    = 1'b0;
      a_state_d     = A_IDLE;
    end
  end
  always_ff @(posedge system_clock) begin
    if (!ext_reset_n) begin
      sync_q        <= 2'b11;
      div_q         <= '0;
      rx_state_q    <= R_IDLE;
      os_q          <= '0;
      bit_q         <= '0;
      rsh_q         <= '0;
      perr_q        <= 1'b0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      a_state_q     <= A_IDLE;
      n_q           <= '0;
      op_q          <= '0;
      acc_q         <= '0;
      to_q          <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_opcode_q  <= '0;
      cmd_data_q    <= '0;
      cmd_long_q    <= 1'b0;
      cmd_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], rx};
      div_q         <= div_d;
      rx_state_q    <= rx_state_d;
      os_q          <= os_d;
      bit_q         <= bit_d;
      rsh_q         <= rsh_d;
      perr_q        <= perr_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      a_state_q     <= a_state_d;
      n_q           <= n_d;
      op_q          <= op_d;
      acc_q         <= acc_d;
      to_q          <= to_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_opcode_q  <= cmd_opcode_d;
      cmd_data_q    <= cmd_data_d;
      cmd_long_q    <= cmd_long_d;
      cmd_busy_q    <= cmd_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_opcode  = cmd_opcode_q;
  assign cmd_data    = cmd_data_q;
  assign cmd_long    = cmd_long_q;
  assign cmd_busy    = cmd_busy_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign timeout_err = timeout_err_q;
endmodule
